// File: rtl/cpu_if.sv
// Instruction fetch stage: drives the instruction-memory request, presents if_pc/if_inst to decode.
// Optional bubble counter output if_bubbles is built when CPU_IF_BUBBLE_COUNT_EN is defined.
module cpu_if #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        c_b,
  input  logic        c_j,
  input  logic [31:0] baddr,
  input  logic [31:0] jaddr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
`ifdef CPU_IF_BUBBLE_COUNT_EN
  output logic [31:0] if_bubbles,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        redirect_pending;
  logic        consumed;

  logic        accept;
  logic        replace;
  logic        capture;
  logic [5:0]  opcode;
  logic [31:0] target;
  logic [31:0] next_pc;

  // Memory handshake: imem_req is a level held with imem_addr stable until a cycle
  // where imem_req & imem_ack; that cycle transfers imem_rdata. A transfer seen while
  // decode stalls is discarded and the same address is requested again later.
  assign accept  = (state == S_FETCH) && !id_stall && imem_ack;
  assign replace = (state == S_FETCH) && !id_stall;
  assign opcode  = if_inst[31:26];

  // One capture per branch/jump held in if_inst; bubbles never qualify.
  assign capture = if_valid && (c_b || c_j) && !redirect_pending && !consumed;

  always_comb begin
    target = baddr;
    if (c_j) begin
      if (opcode == 6'h02 || opcode == 6'h03)
        target = {pc[31:28], jaddr[25:0], 2'b00};
      else
        target = jaddr;
    end
  end

  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect_pending)
      next_pc = redirect_pc;
    else if (capture)
      next_pc = target;
  end

  assign imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_START;
      pc               <= RESET_VECTOR;
      imem_req         <= 1'b0;
      if_pc            <= 32'h0;
      if_inst          <= 32'h0;
      if_valid         <= 1'b0;
      redirect_pc      <= 32'h0;
      redirect_pending <= 1'b0;
      consumed         <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (id_stall) begin
            state    <= S_STALL;
            imem_req <= 1'b0;
          end else if (imem_ack) begin
            if_inst  <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= next_pc;
          end else begin
            if_inst  <= 32'h0;
            if_valid <= 1'b0;
          end
        end
        S_STALL: begin
          if (!id_stall) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_START;
          imem_req <= 1'b0;
        end
      endcase

      // The accept that fetches the delay slot is the one that consumes the redirect.
      if (accept)
        redirect_pending <= 1'b0;
      else if (capture)
        redirect_pending <= 1'b1;

      if (capture && !accept)
        redirect_pc <= target;

      if (replace)
        consumed <= 1'b0;
      else if (capture)
        consumed <= 1'b1;
    end
  end

`ifdef CPU_IF_BUBBLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      if_bubbles <= 32'h0;
    else if (state == S_FETCH && !if_valid && if_bubbles != 32'hFFFF_FFFF)
      if_bubbles <= if_bubbles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_if.sv
// Bench for cpu_if: per-cycle vector table, directed branch/stall/reset sequences and
// randomized memory wait states and stalls checked against a program-order model.
module tb_cpu_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        c_b = 1'b0;
  logic        c_j = 1'b0;
  logic [31:0] baddr = 32'h0;
  logic [31:0] jaddr = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [1:0]  dbg_state;
`ifdef CPU_IF_BUBBLE_COUNT_EN
  logic [31:0] if_bubbles;
`endif

  cpu_if #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .c_b        (c_b),
    .c_j        (c_j),
    .baddr      (baddr),
    .jaddr      (jaddr),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid),
`ifdef CPU_IF_BUBBLE_COUNT_EN
    .if_bubbles (if_bubbles),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_pass = 0;
  int          n_checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] deliv[$];
  logic [31:0] jr_reg;
  int          wmode;
  int          stall_pct;
  bit          garbage;
  bit          stall_br;
  int          br_stall_cnt;
  bit          br_stall_done;
  int          wl;
  int          got;
  logic        prev_req, prev_ack, prev_stall, first_edge, prev_valid;
  logic [31:0] prev_pc, prev_inst, prev_addr;

  localparam logic [31:0] BEQ_W = 32'h1000_0003;  // beq imm=3 at 0x10
  localparam logic [31:0] J_W   = 32'h0800_0080;  // j index 0x80 at 0x100
  localparam logic [31:0] JR_W  = 32'h2000_0000;  // jr at 0x200

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- program and reference model ----------------
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return BEQ_W;
      32'h0000_0100: return J_W;
      32'h0000_0200: return JR_W;
      default:       return a;
    endcase
  endfunction

  function automatic bit is_xfer(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return op == 6'h04 || op == 6'h02 || op == 6'h03 || op == 6'h08 || op == 6'h09;
  endfunction

  function automatic logic [31:0] xfer_target(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] ds;
    ds = a + 32'd4;
    case (w[31:26])
      6'h04:       return a + {{14{w[15]}}, w[15:0], 2'b00};
      6'h02, 6'h03: return {ds[31:28], w[25:0], 2'b00};
      default:     return jr_reg;
    endcase
  endfunction

  // Program order: every instruction, the delay slot after a transfer, then its target.
  task automatic build_exp(input int n);
    logic [31:0] a;
    exp_q.delete();
    deliv.delete();
    a = 32'h0;
    while (exp_q.size() < n + 4) begin
      exp_q.push_back(a);
      if (is_xfer(word(a))) begin
        exp_q.push_back(a + 32'd4);
        a = xfer_target(a, word(a));
      end else begin
        a = a + 32'd4;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_inst", if_inst, 32'h0);
    check("reset if_valid", {31'h0, if_valid}, 32'h0);
    check("reset imem_req", {31'h0, imem_req}, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    id_stall = 1'b0;
    c_b = 1'b0;
    c_j = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; first_edge = 1'b1;
    prev_valid = 1'b0; prev_pc = 32'h0; prev_inst = 32'h0; prev_addr = 32'h0;
    wl = -1;
    got = 0;
    br_stall_cnt = 0;
    br_stall_done = 1'b0;
  endtask

  task automatic drive();
    logic [5:0] op;
    if (stall_br) begin
      if (if_valid && if_inst == BEQ_W && !br_stall_done) begin
        br_stall_cnt = 3;
        br_stall_done = 1'b1;
      end
      id_stall = (br_stall_cnt > 0);
      if (br_stall_cnt > 0) br_stall_cnt--;
    end else begin
      id_stall = ($urandom_range(0, 99) < stall_pct);
    end
    if (imem_req) begin
      if (wl < 0) wl = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
      imem_ack = (wl == 0);
      imem_rdata = imem_ack ? word(imem_addr) : $urandom;
    end else begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    op = if_inst[31:26];
    if (if_valid) begin
      c_b = (op == 6'h04);
      c_j = (op == 6'h02 || op == 6'h03 || op == 6'h08 || op == 6'h09);
      baddr = if_pc + {{14{if_inst[15]}}, if_inst[15:0], 2'b00};
      jaddr = (op == 6'h02 || op == 6'h03) ? {6'h0, if_inst[25:0]} : jr_reg;
    end else if (garbage) begin
      c_b = 1'($urandom_range(0, 1));
      c_j = 1'($urandom_range(0, 1));
      baddr = $urandom;
      jaddr = $urandom;
    end else begin
      c_b = 1'b0;
      c_j = 1'b0;
    end
    prev_ack = imem_ack;
    prev_stall = id_stall;
  endtask

  task automatic step();
    logic        accepted;
    logic [31:0] e;
    @(posedge clk);
    #1;
    accepted = prev_req && prev_ack && !prev_stall;
    if (!imem_req || accepted) wl = -1;
    else if (prev_req && !prev_ack) wl--;
    if (accepted) begin
      if (exp_q.size() == 0) begin
        check("delivery beyond model", if_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("delivered if_valid", {31'h0, if_valid}, 32'h1);
        check("delivered if_pc", if_pc, e);
        check("delivered if_inst", if_inst, word(e));
      end
      deliv.push_back(if_pc);
      got++;
    end else if (prev_req && !prev_stall) begin
      check("bubble if_valid", {31'h0, if_valid}, 32'h0);
      check("bubble if_inst", if_inst, 32'h0);
      check("bubble if_pc hold", if_pc, prev_pc);
    end else begin
      check("hold if_pc", if_pc, prev_pc);
      check("hold if_inst", if_inst, prev_inst);
      check("hold if_valid", {31'h0, if_valid}, {31'h0, prev_valid});
    end
    if (prev_stall && !first_edge)
      check("stall imem_req", {31'h0, imem_req}, 32'h0);
    if (prev_req && imem_req && !accepted)
      check("imem_addr stable", imem_addr, prev_addr);
    prev_req = imem_req; prev_pc = if_pc; prev_inst = if_inst;
    prev_valid = if_valid; prev_addr = imem_addr;
    first_edge = 1'b0;
    drive();
  endtask

  task automatic run_until(input int n);
    int cycles;
    cycles = 0;
    while (got < n && cycles < n * 12 + 60) begin
      step();
      cycles++;
    end
    check("delivery count within budget", got, n);
  endtask

  task automatic run_prog(input int n);
    do_reset();
    build_exp(n);
    drive();
    run_until(n);
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    logic        ack;
    logic        stall;
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 32'h00, 32'h04};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 32'h04, 32'h08};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 32'h08, 32'h0C};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h00, 32'h0C};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h00, 32'h0C};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 32'h0C, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h00, 32'h10};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h00, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h10, 32'h14};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h10, 32'h14};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h10, 32'h14};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h10, 32'h14};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 32'h14, 32'h18};

    jr_reg = 32'h40; wmode = 0; stall_pct = 0; garbage = 1'b0; stall_br = 1'b0;

    // Table: start-up, zero-wait, 2-wait bubbles, 2-cycle stall.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      imem_ack = tbl[i].ack;
      imem_rdata = imem_addr;
      id_stall = tbl[i].stall;
      c_b = 1'b0;
      c_j = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d] imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      check($sformatf("tbl[%0d] if_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].valid});
      check($sformatf("tbl[%0d] if_pc", i), if_pc, tbl[i].pc);
      check($sformatf("tbl[%0d] if_inst", i), if_inst, tbl[i].inst);
      check($sformatf("tbl[%0d] imem_addr", i), imem_addr, tbl[i].addr);
    end

    // Zero-wait program: beq delay slot, j and jr targets.
    wmode = 0;
    run_prog(70);
    if (deliv.size() >= 68) begin
      check("zw beq", deliv[4], 32'h10);
      check("zw beq delay slot", deliv[5], 32'h14);
      check("zw beq target", deliv[6], 32'h1C);
      check("zw j", deliv[63], 32'h100);
      check("zw j delay slot", deliv[64], 32'h104);
      check("zw j target", deliv[65], 32'h200);
      check("zw jr delay slot", deliv[66], 32'h204);
      check("zw jr target", deliv[67], 32'h40);
    end else begin
      check("zw delivered count", deliv.size(), 68);
    end

    // Three wait states per fetch, same program.
    wmode = 3;
    run_prog(70);
    if (deliv.size() >= 7) begin
      check("w3 beq delay slot", deliv[5], 32'h14);
      check("w3 beq target", deliv[6], 32'h1C);
    end

    // Decode stalls 3 cycles while the taken beq is held.
    wmode = 0; stall_br = 1'b1;
    run_prog(12);
    check("stall run stalled once", {31'h0, br_stall_done}, 32'h1);
    if (deliv.size() >= 7) check("stall beq target", deliv[6], 32'h1C);
    stall_br = 1'b0;

    // Reset while a fetch is outstanding and a redirect is pending.
    wmode = 3;
    run_prog(5);
    step();
    check("pre-reset request active", {31'h0, imem_req}, 32'h1);
    do_reset();
    build_exp(10);
    drive();
    run_until(10);
    if (deliv.size() >= 3) begin
      check("post-reset first fetch", deliv[0], 32'h0);
      check("post-reset no stale redirect", deliv[1], 32'h4);
    end

    // Random waits, random stalls, noise on branch inputs during bubbles, address wrap.
    jr_reg = 32'hFFFF_FFF0; wmode = -1; stall_pct = 20; garbage = 1'b1;
    run_prog(250);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
